// File: rtl/uart_rx_cfg_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding, majority voter.
// No ports; imported by the receiver and its bit sampler.
package uart_rx_cfg_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_sampler.sv
// 2-FF line synchroniser plus 3-sample majority voter around mid-bit.
// Ports: clock/reset_n/tick/rx/tick_cnt in; rx_s, bit_val, bit_valid out.
module uart_rx_cfg_sampler
  import uart_rx_cfg_pkg::*;
#(
  parameter int SB_TICK = 16,
  parameter int TW      = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          rx,
  input  logic [TW-1:0] tick_cnt,
  output logic          rx_s,
  output logic          bit_val,
  output logic          bit_valid
);

  localparam logic [TW-1:0] MID_M1 = TW'(SB_TICK / 2 - 2);
  localparam logic [TW-1:0] MID_C  = TW'(SB_TICK / 2 - 1);
  localparam logic [TW-1:0] MID_P1 = TW'(SB_TICK / 2);

  logic meta;
  logic s0;
  logic s1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      s0   <= 1'b1;
      s1   <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
      if (tick && tick_cnt == MID_M1) s0 <= rx_s;
      if (tick && tick_cnt == MID_C)  s1 <= rx_s;
    end
  end

  // Third vote is the live sample on the MID+1 tick.
  assign bit_val   = maj3(s0, s1, rx_s);
  assign bit_valid = tick && (tick_cnt == MID_P1);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: NB_DATA bits, optional parity, 1-2 stops.
// Ports: i_clock, i_reset_n, i_tick, i_rx in; data, done, errors, busy out.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0,
  parameter int NB_STOP = 1
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam int TW = $clog2(SB_TICK);
  localparam logic [TW-1:0] LAST_T = TW'(SB_TICK - 1);
  localparam logic [3:0]    LAST_D = 4'(NB_DATA - 1);
  localparam logic [3:0]    LAST_S = 4'(NB_STOP - 1);

  rx_state_t          state, state_n;
  logic [TW-1:0]      tcnt, tcnt_n;
  logic [3:0]         bcnt, bcnt_n;
  logic [NB_DATA-1:0] shreg, shreg_n;
  logic               perr, perr_n;
  logic               ferr, ferr_n;
  logic               fin;
  logic               rx_s;
  logic               bv;
  logic               bvld;
  logic               par_exp;

  uart_rx_cfg_sampler #(
    .SB_TICK(SB_TICK),
    .TW     (TW)
  ) u_sampler (
    .clock    (i_clock),
    .reset_n  (i_reset_n),
    .tick     (i_tick),
    .rx       (i_rx),
    .tick_cnt (tcnt),
    .rx_s     (rx_s),
    .bit_val  (bv),
    .bit_valid(bvld)
  );

  assign par_exp = (PARITY == PARITY_ODD) ? ~^shreg : ^shreg;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    perr_n  = perr;
    ferr_n  = ferr;
    fin     = 1'b0;
    if (i_tick) begin
      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_n = ST_START;
            tcnt_n  = '0;
          end
        end
        ST_START: begin
          tcnt_n = tcnt + 1'b1;
          if (bvld && bv) begin
            state_n = ST_IDLE;
          end else if (tcnt == LAST_T) begin
            state_n = ST_DATA;
            tcnt_n  = '0;
            bcnt_n  = '0;
            perr_n  = 1'b0;
            ferr_n  = 1'b0;
          end
        end
        ST_DATA: begin
          tcnt_n = tcnt + 1'b1;
          if (bvld) shreg_n = {bv, shreg[NB_DATA-1:1]};
          if (tcnt == LAST_T) begin
            tcnt_n = '0;
            if (bcnt == LAST_D) begin
              bcnt_n  = '0;
              state_n = (PARITY == PARITY_NONE)
                      ? ST_STOP : ST_PARITY;
            end else begin
              bcnt_n = bcnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          tcnt_n = tcnt + 1'b1;
          if (bvld) perr_n = (bv != par_exp);
          if (tcnt == LAST_T) begin
            tcnt_n  = '0;
            state_n = ST_STOP;
          end
        end
        ST_STOP: begin
          tcnt_n = tcnt + 1'b1;
          if (bvld) begin
            if (!bv) ferr_n = 1'b1;
            // Last stop ends the frame mid-bit so a
            // following start edge is not missed.
            if (bcnt == LAST_S) begin
              fin     = 1'b1;
              tcnt_n  = '0;
              bcnt_n  = '0;
              state_n = (shreg == '0 && ferr_n)
                      ? ST_BREAK_WAIT : ST_IDLE;
            end
          end else if (tcnt == LAST_T) begin
            tcnt_n = '0;
            bcnt_n = bcnt + 1'b1;
          end
        end
        ST_BREAK_WAIT: begin
          if (rx_s) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tcnt         <= '0;
      bcnt         <= '0;
      shreg        <= '0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      o_rx_data    <= '0;
      o_rx_done    <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      tcnt      <= tcnt_n;
      bcnt      <= bcnt_n;
      shreg     <= shreg_n;
      perr      <= perr_n;
      ferr      <= ferr_n;
      o_rx_done <= fin;
      if (fin) begin
        o_rx_data    <= shreg;
        o_parity_err <= perr_n;
        o_frame_err  <= ferr_n;
      end
    end
  end

  assign o_busy = (state != ST_IDLE) &&
                  (state != ST_BREAK_WAIT);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: 8N1, 8E1 and 8N2 instances on one clock/tick.
// Ports: none; scoreboard queues per instance, negedge monitor pops.
module tb_uart_rx_cfg;

  localparam int TPER = 4;
  localparam int BIT  = TPER * 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic       tk_d  = 1'b0;
  logic [2:0] rx    = 3'b111;
  logic [7:0] data [3];
  logic [2:0] done;
  logic [2:0] perr;
  logic [2:0] ferr;
  logic [2:0] busy;
  logic [2:0] done_d = '0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_chk  = 0;
  int n_fail = 0;

  uart_rx_cfg #(.NB_DATA(8), .SB_TICK(16),
                .PARITY(0), .NB_STOP(1)) u_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick),
    .i_rx(rx[0]), .o_rx_data(data[0]), .o_rx_done(done[0]),
    .o_parity_err(perr[0]), .o_frame_err(ferr[0]),
    .o_busy(busy[0]));

  uart_rx_cfg #(.NB_DATA(8), .SB_TICK(16),
                .PARITY(1), .NB_STOP(1)) u_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick),
    .i_rx(rx[1]), .o_rx_data(data[1]), .o_rx_done(done[1]),
    .o_parity_err(perr[1]), .o_frame_err(ferr[1]),
    .o_busy(busy[1]));

  uart_rx_cfg #(.NB_DATA(8), .SB_TICK(16),
                .PARITY(0), .NB_STOP(2)) u_c (
    .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick),
    .i_rx(rx[2]), .o_rx_data(data[2]), .o_rx_done(done[2]),
    .o_parity_err(perr[2]), .o_frame_err(ferr[2]),
    .o_busy(busy[2]));

  always #5 clk = ~clk;

  initial begin
    int tc;
    tc = 0;
    forever begin
      @(negedge clk);
      tick = (tc == TPER - 1);
      tc   = (tc == TPER - 1) ? 0 : tc + 1;
    end
  end

  always @(posedge clk) tk_d <= tick;

  initial begin
    #5ms;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return 0;
    endcase
  endfunction

  task automatic mon(input int d, input logic was_done);
    exp_t e;
    if (qsize(d) == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_done dut%0d: data %0h",
               d, data[d]);
    end else begin
      case (d)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("data dut%0d", d), int'(data[d]),
          int'(e.d));
      chk($sformatf("parity_err dut%0d", d), int'(perr[d]),
          int'(e.pe));
      chk($sformatf("frame_err dut%0d", d), int'(ferr[d]),
          int'(e.fe));
      chk($sformatf("done_latency dut%0d", d), int'(tk_d), 1);
      chk($sformatf("done_width dut%0d", d), int'(was_done), 0);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i]) mon(i, done_d[i]);
    end
    done_d <= done;
  end

  task automatic drive(input int d, input logic v,
                       input int clocks);
    rx[d] = v;
    repeat (clocks) @(negedge clk);
  endtask

  task automatic frame(input int d, input logic [7:0] w,
                       input bit has_par, input logic pbit,
                       input int nstop, input logic sbit);
    drive(d, 1'b0, BIT);
    chk($sformatf("busy_in_frame dut%0d", d),
        int'(busy[d]), 1);
    for (int i = 0; i < 8; i++) drive(d, w[i], BIT);
    if (has_par) drive(d, pbit, BIT);
    for (int s = 0; s < nstop; s++) drive(d, sbit, BIT);
  endtask

  task automatic wait_empty(input int d, input string nm);
    int k;
    k = 0;
    while (qsize(d) != 0 && k < 20 * BIT) begin
      @(negedge clk);
      k++;
    end
    chk(nm, qsize(d), 0);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("reset_data", int'(data[0]), 0);
    chk("reset_done", int'(done[0]), 0);
    chk("reset_perr", int'(perr[0]), 0);
    chk("reset_ferr", int'(ferr[0]), 0);
    chk("reset_busy", int'(busy[0]), 0);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);

    // 8N1 0xAA
    q0.push_back({8'hAA, 1'b0, 1'b0});
    frame(0, 8'hAA, 1'b0, 1'b0, 1, 1'b1);
    wait_empty(0, "t1_pending");
    drive(0, 1'b1, BIT);
    chk("t1_busy_idle", int'(busy[0]), 0);

    // 8E1 0x37 with wrong parity bit
    q1.push_back({8'h37, 1'b1, 1'b0});
    frame(1, 8'h37, 1'b1, 1'b0, 1, 1'b1);
    wait_empty(1, "t2_pending");

    // glitch of 4 ticks: false start
    drive(0, 1'b0, 4 * TPER);
    drive(0, 1'b1, 12 * TPER);
    chk("t3_busy", int'(busy[0]), 0);
    drive(0, 1'b1, 2 * BIT);
    chk("t3_data_hold", int'(data[0]), 'hAA);

    // break: 0x00 with low stop, then line low
    q0.push_back({8'h00, 1'b0, 1'b1});
    frame(0, 8'h00, 1'b0, 1'b0, 1, 1'b0);
    drive(0, 1'b0, 3 * BIT);
    wait_empty(0, "t4_break_pending");
    chk("t4_break_busy", int'(busy[0]), 0);
    chk("t4_ferr_hold", int'(ferr[0]), 1);
    drive(0, 1'b1, 2 * BIT);
    q0.push_back({8'h81, 1'b0, 1'b0});
    frame(0, 8'h81, 1'b0, 1'b0, 1, 1'b1);
    wait_empty(0, "t4_pending");

    // 8N2 back-to-back
    q2.push_back({8'h55, 1'b0, 1'b0});
    q2.push_back({8'hC3, 1'b0, 1'b0});
    frame(2, 8'h55, 1'b0, 1'b0, 2, 1'b1);
    frame(2, 8'hC3, 1'b0, 1'b0, 2, 1'b1);
    wait_empty(2, "t5_pending");

    // reset during data bit 3
    drive(0, 1'b1, BIT);
    drive(0, 1'b0, BIT);
    drive(0, 1'b0, BIT);
    drive(0, 1'b1, BIT);
    drive(0, 1'b0, BIT);
    drive(0, 1'b1, BIT / 2);
    chk("t6_busy_pre", int'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_data", int'(data[0]), 0);
    chk("t6_rst_done", int'(done[0]), 0);
    chk("t6_rst_perr", int'(perr[0]), 0);
    chk("t6_rst_ferr", int'(ferr[0]), 0);
    chk("t6_rst_busy", int'(busy[0]), 0);
    rx[0] = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, BIT);
    q0.push_back({8'h5A, 1'b0, 1'b0});
    frame(0, 8'h5A, 1'b0, 1'b0, 1, 1'b1);
    wait_empty(0, "t6_pending");
    drive(0, 1'b1, BIT);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
